// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of branch predictions between IF and EX.
// Each EX pop checks the oldest record against the real outcome, sends a
// training pulse to the predictor and, on a mispredict, redirects fetch
// and empties the queue.
module branch_resolver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        pr_valid,
  input  logic [31:0] pr_pc,
  input  logic        pr_taken,
  input  logic [31:0] pr_target,
  output logic        pr_ready,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] upd_addr,
  output logic        upd_jmp,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // Record storage: data only, no reset needed.
  logic [31:0] pc_mem [DEPTH];
  logic        tk_mem [DEPTH];
  logic [31:0] tg_mem [DEPTH];

  // Control state
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          pr_ready_q;
  logic          err_q, err_d;

  // Output registers
  logic          upd_jmp_q, flush_q, upd_taken_q;
  logic [31:0]   upd_addr_q, upd_target_q, redirect_pc_q;
  logic [31:0]   br_cnt_q, miss_cnt_q;

  // Decoded events for this cycle
  logic          push, pop, br_pop, stale, mis, upd;
  logic [31:0]   hd_pc, hd_tg;
  logic          hd_tk;
  logic          eff_taken;

  assign hd_pc = pc_mem[head_q];
  assign hd_tk = tk_mem[head_q];
  assign hd_tg = tg_mem[head_q];

  // Classify the current cycle's push/pop and resolve the head record.
  always_comb begin
    eff_taken = ex_is_br & ex_taken;
    push      = pr_valid & rdy & pr_ready_q & ~flush_q;
    pop       = ex_valid & rdy & (count_q != '0);
    br_pop    = pop & ex_is_br;
    // A non-branch that the BTB predicted taken fetched down a bogus path.
    stale     = pop & ~ex_is_br & hd_tk;
    mis       = (br_pop & ((hd_tk != ex_taken) | (ex_taken & (hd_tg != ex_target)))) | stale;
    upd       = br_pop | stale;
  end

  // Next-state for pointers, occupancy and the sticky error flag.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (mis) begin
      // Mispredict discards everything younger, including a same-cycle push.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    if (ex_valid && rdy && (count_q == '0)) err_d = 1'b1;
    if (pr_valid && rdy && !pr_ready_q)     err_d = 1'b1;
  end

  // Record write at tail; skipped when a mispredict kills the push.
  always_ff @(posedge clk) begin
    if (push && !mis) begin
      pc_mem[tail_q] <= pr_pc;
      tk_mem[tail_q] <= pr_taken;
      tg_mem[tail_q] <= pr_target;
    end
  end

  // Queue control state; pr_ready is derived from the next count so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      pr_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pr_ready_q <= (count_d != CNT_FULL);
      err_q      <= err_d;
    end
  end

  // One-cycle strobes; pop/mis are already gated by rdy so a stall drops them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_jmp_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      upd_jmp_q <= upd;
      flush_q   <= mis;
    end
  end

  // Update/redirect payload and counters; payload holds while strobes are low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      miss_cnt_q    <= '0;
    end else begin
      if (upd) begin
        upd_addr_q   <= hd_pc;
        upd_taken_q  <= eff_taken;
        upd_target_q <= ex_target;
        br_cnt_q     <= br_cnt_q + 32'd1;
      end
      if (mis) begin
        redirect_pc_q <= eff_taken ? ex_target : (hd_pc + 32'd4);
        miss_cnt_q    <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign pr_ready    = pr_ready_q;
  assign upd_addr    = upd_addr_q;
  assign upd_jmp     = upd_jmp_q;
  assign upd_taken   = upd_taken_q;
  assign upd_target  = upd_target_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign br_cnt      = br_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus queues hand-computed
// expected update/flush events; a negedge monitor pops and compares them.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        pr_valid = 1'b0;
  logic [31:0] pr_pc = '0;
  logic        pr_taken = 1'b0;
  logic [31:0] pr_target = '0;
  logic        pr_ready;
  logic        ex_valid = 1'b0;
  logic        ex_is_br = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] upd_addr;
  logic        upd_jmp;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic        tk;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] rpc;
    logic [31:0] br;
    logic [31:0] miss;
  } ev_t;

  ev_t sb[$];

  branch_resolver #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pr_valid(pr_valid), .pr_pc(pr_pc), .pr_taken(pr_taken), .pr_target(pr_target),
    .pr_ready(pr_ready),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_addr(upd_addr), .upd_jmp(upd_jmp), .upd_taken(upd_taken), .upd_target(upd_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (upd_jmp || flush)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: upd_jmp=%0b flush=%0b upd_addr=0x%08h, none expected (t=%0t)",
                 upd_jmp, flush, upd_addr, $time);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("upd_jmp",     {31'd0, upd_jmp},   32'd1);
        chk("upd_addr",    upd_addr,           e.addr);
        chk("upd_taken",   {31'd0, upd_taken}, {31'd0, e.tk});
        chk("upd_target",  upd_target,         e.tgt);
        chk("flush",       {31'd0, flush},     {31'd0, e.fl});
        chk("redirect_pc", redirect_pc,        e.rpc);
        chk("br_cnt",      br_cnt,             e.br);
        chk("miss_cnt",    miss_cnt,           e.miss);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [31:0] addr, input logic tk, input logic [31:0] tgt,
                           input logic fl, input logic [31:0] rpc,
                           input logic [31:0] br, input logic [31:0] miss);
    ev_t e;
    e.addr = addr; e.tk = tk; e.tgt = tgt; e.fl = fl; e.rpc = rpc; e.br = br; e.miss = miss;
    sb.push_back(e);
  endtask

  // One cycle with optional push and optional pop.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic ptk, input logic [31:0] ptg,
                      input logic ev, input logic ebr, input logic etk, input logic [31:0] etg);
    pr_valid = pv; pr_pc = ppc; pr_taken = ptk; pr_target = ptg;
    ex_valid = ev; ex_is_br = ebr; ex_taken = etk; ex_target = etg;
    cyc();
    pr_valid = 1'b0;
    ex_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    step(1'b1, pc, tk, tg, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic pop(input logic br, input logic tk, input logic [31:0] tg);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, br, tk, tg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pr_ready", {31'd0, pr_ready}, 32'd1);
    chk("rst_flush",    {31'd0, flush},    32'd0);
    chk("rst_upd_jmp",  {31'd0, upd_jmp},  32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_br_cnt",   br_cnt,            32'd0);
    chk("rst_miss_cnt", miss_cnt,          32'd0);
    rst_n = 1'b1;
    cyc();

    // Correct taken prediction
    push(32'h100, 1'b1, 32'h200);
    expect_ev(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 32'd1, 32'd0);
    pop(1'b1, 1'b1, 32'h200);

    // Direction miss: predicted not-taken, went to 0x80
    push(32'h104, 1'b0, 32'h0);
    expect_ev(32'h104, 1'b1, 32'h80, 1'b1, 32'h80, 32'd2, 32'd1);
    pop(1'b1, 1'b1, 32'h80);
    chk("dirmiss_pr_ready", {31'd0, pr_ready}, 32'd1);
    cyc();

    // Target miss: predicted 0x200, actual 0x300
    push(32'h180, 1'b1, 32'h200);
    expect_ev(32'h180, 1'b1, 32'h300, 1'b1, 32'h300, 32'd3, 32'd2);
    pop(1'b1, 1'b1, 32'h300);
    cyc();

    // Stale BTB hit on a non-branch at 0x10
    push(32'h10, 1'b1, 32'h40);
    expect_ev(32'h10, 1'b0, 32'h14, 1'b1, 32'h14, 32'd4, 32'd3);
    pop(1'b0, 1'b0, 32'h14);
    cyc();

    // Non-branch predicted not-taken: silent
    push(32'h20, 1'b0, 32'h0);
    pop(1'b0, 1'b0, 32'h24);

    // Flush race: mispredicting pop with a same-cycle push of 0x400
    push(32'h300, 1'b0, 32'h0);
    expect_ev(32'h300, 1'b1, 32'h600, 1'b1, 32'h600, 32'd5, 32'd4);
    step(1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 1'b1, 1'b1, 32'h600);
    chk("race_err_before", {31'd0, err}, 32'd0);
    // Queue must now be empty: this pop is an error and resolves nothing
    pop(1'b1, 1'b1, 32'h500);
    chk("empty_pop_err", {31'd0, err},      32'd1);
    chk("race_pr_ready", {31'd0, pr_ready}, 32'd1);
    chk("race_br_cnt",   br_cnt,            32'd5);
    cyc();

    // Asynchronous reset while a flush pulse is showing
    push(32'h700, 1'b0, 32'h0);
    pop(1'b1, 1'b1, 32'h800);
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_flush",    {31'd0, flush},   32'd0);
    chk("async_upd_jmp",  {31'd0, upd_jmp}, 32'd0);
    chk("async_err",      {31'd0, err},     32'd0);
    chk("async_br_cnt",   br_cnt,           32'd0);
    chk("async_miss_cnt", miss_cnt,         32'd0);
    chk("async_redirect", redirect_pc,      32'd0);
    chk("async_upd_addr", upd_addr,         32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_pr_ready", {31'd0, pr_ready}, 32'd1);

    // Stall during a resolve: nothing happens, state held
    push(32'h500, 1'b1, 32'h600);
    rdy = 1'b0;
    step(1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h700);
    chk("stall_upd_jmp", {31'd0, upd_jmp}, 32'd0);
    chk("stall_flush",   {31'd0, flush},   32'd0);
    chk("stall_br_cnt",  br_cnt,           32'd0);
    rdy = 1'b1;
    expect_ev(32'h500, 1'b1, 32'h600, 1'b0, 32'h0, 32'd1, 32'd0);
    pop(1'b1, 1'b1, 32'h600);
    cyc();

    // Fill the queue
    push(32'h1000, 1'b0, 32'h0);
    push(32'h1004, 1'b1, 32'h2000);
    push(32'h2000, 1'b0, 32'h0);
    push(32'h2004, 1'b0, 32'h0);
    chk("full_pr_ready", {31'd0, pr_ready}, 32'd0);
    chk("full_err_before", {31'd0, err},    32'd0);
    push(32'hdead0000, 1'b1, 32'hbeef0000);
    chk("overflow_err",      {31'd0, err},      32'd1);
    chk("overflow_pr_ready", {31'd0, pr_ready}, 32'd0);

    // Drain one, then push+pop together, then refill to full
    expect_ev(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 32'd2, 32'd0);
    pop(1'b1, 1'b0, 32'h0);
    chk("pop_pr_ready", {31'd0, pr_ready}, 32'd1);
    expect_ev(32'h1004, 1'b1, 32'h2000, 1'b0, 32'h0, 32'd3, 32'd0);
    step(1'b1, 32'h2008, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 32'h2000);
    chk("pushpop_pr_ready", {31'd0, pr_ready}, 32'd1);
    push(32'h200c, 1'b0, 32'h0);
    chk("refill_pr_ready", {31'd0, pr_ready}, 32'd0);

    // Drain in FIFO order across the pointer wrap
    expect_ev(32'h2000, 1'b0, 32'h0,    1'b0, 32'h0, 32'd4, 32'd0);
    pop(1'b1, 1'b0, 32'h0);
    expect_ev(32'h2004, 1'b0, 32'h0,    1'b0, 32'h0, 32'd5, 32'd0);
    pop(1'b1, 1'b0, 32'h0);
    expect_ev(32'h2008, 1'b1, 32'h3000, 1'b0, 32'h0, 32'd6, 32'd0);
    pop(1'b1, 1'b1, 32'h3000);
    expect_ev(32'h200c, 1'b0, 32'h0,    1'b0, 32'h0, 32'd7, 32'd0);
    pop(1'b1, 1'b0, 32'h0);
    chk("drain_pr_ready", {31'd0, pr_ready}, 32'd1);
    chk("drain_miss_cnt", miss_cnt,          32'd0);

    repeat (3) cyc();
    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_err", {31'd0, err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
